ext_bus_master: RTL and testbench

- CPU-side initiator that turns one single-byte read/write request into the multiplexed external bus transaction consumed by the external address/data interface.
- Serialises the 32-bit address as two 16-bit AE beats, low half first, then high half.
- Runs the data phase on EXT_AD[7:0], waits for completion, and returns one response per request.
- Sits directly upstream of the interface; completion comes from EXT_READY/DT for off-chip targets and from EXT_AD for on-interface I/O registers.

---
 rtl/ext_bus_master_if.sv | 36 +++
 rtl/ext_bus_master.sv | 190 +++++++++++++++++++
 tb/tb_ext_bus_master.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_master_if.sv
// ---------------------------------------------------------------------------
// ext_bus_master_if
// Request/response handshake plus the external bus control pins of the
// external bus master. EXT_AD is not carried here. It is a bidirectional
// tri-state bus, so it stays a plain inout port of the master.
//
//   req_valid/req_ready/req_we/req_addr/req_wdata : CPU request channel
//   rsp_valid/rsp_rdata/rsp_err                   : CPU response channel
//   AE/EXT_read/EXT_write                         : bus strobes from master
//   EXT_READY/DT                                  : off-chip completion/data
// ---------------------------------------------------------------------------
interface ext_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        AE;
    logic        EXT_read;
    logic        EXT_write;
    logic        EXT_READY;
    logic [7:0]  DT;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, EXT_READY, DT,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, AE, EXT_read, EXT_write
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, EXT_READY, DT,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, AE, EXT_read, EXT_write
    );
endinterface

// File: rtl/ext_bus_master.sv
// ---------------------------------------------------------------------------
// ext_bus_master
// Turns one single-byte CPU read/write request into a multiplexed external
// bus transaction. The transaction has two 16-bit address beats (low half,
// then high half) qualified by AE, followed by one byte-wide data phase.
// The master returns exactly one response per accepted request.
//
// Ports:
//   clk     : system clock. All flops are on the rising edge except AE,
//             which is on the falling edge.
//   rst     : synchronous active-high reset.
//   bus     : ext_bus_master_if.master. Carries the request/response
//             channels, AE, EXT_read, EXT_write, EXT_READY and DT.
//   EXT_AD  : 16-bit multiplexed address/data bus. It is tri-stated
//             whenever the master is not driving it.
// ---------------------------------------------------------------------------
module ext_bus_master #(
    parameter int          TIMEOUT = 64,
    parameter logic [11:0] IO_TAG  = 12'h1A1
) (
    input  logic               clk,
    input  logic               rst,
    ext_bus_master_if.master   bus,
    inout  wire  [15:0]        EXT_AD
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_LO = 3'd1;
    localparam logic [2:0] S_ADDR_HI = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [1:0] C_IO  = 2'd0;
    localparam logic [1:0] C_UNM = 2'd1;
    localparam logic [1:0] C_OFF = 2'd2;

    localparam int               CNT_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    logic [2:0]       r_state;
    logic [31:0]      r_addr;
    logic             r_we;
    logic [7:0]       r_wdata;
    logic [1:0]       r_cls;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_rdata;
    logic             r_rsp_err;
    logic             r_ext_read;
    logic             r_ext_write;
    logic             r_ae;

    logic [1:0]       w_cls;
    logic             w_drv_hi;
    logic             w_drv_lo;
    logic [15:0]      w_ad;

    // Address class of the incoming request. It only matters at accept.
    always_comb begin
        w_cls = C_OFF;
        if (bus.req_addr[31:20] == IO_TAG && bus.req_addr[19:17] == 3'b000)
            w_cls = C_IO;
        else if (bus.req_addr[31:12] == 20'h0)
            w_cls = C_UNM;
    end

    // EXT_AD is driven directly from the state. Each beat therefore appears
    // at the same rising edge that enters its state.
    // A write data phase drives only the low byte. The high byte stays
    // released.
    always_comb begin
        w_drv_hi = 1'b0;
        w_drv_lo = 1'b0;
        w_ad     = r_addr[15:0];
        case (r_state)
            S_ADDR_LO: begin
                w_drv_hi = 1'b1;
                w_drv_lo = 1'b1;
                w_ad     = r_addr[15:0];
            end
            S_ADDR_HI: begin
                w_drv_hi = 1'b1;
                w_drv_lo = 1'b1;
                w_ad     = r_addr[31:16];
            end
            S_DATA: begin
                w_drv_lo = r_we;
                w_ad     = {8'h00, r_wdata};
            end
            default: ;
        endcase
    end

    assign EXT_AD[15:8] = w_drv_hi ? w_ad[15:8] : 8'hzz;
    assign EXT_AD[7:0]  = w_drv_lo ? w_ad[7:0]  : 8'hzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b0;
            r_ext_read  <= 1'b0;
            r_ext_write <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_addr      <= bus.req_addr;
                        r_we        <= bus.req_we;
                        r_wdata     <= bus.req_wdata;
                        r_cls       <= w_cls;
                        r_req_ready <= 1'b0;
                        if (w_cls == C_UNM) begin
                            // No bus cycle for unmapped space. Reply with an error.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 8'h00;
                        end else begin
                            r_state <= S_ADDR_LO;
                        end
                    end
                end
                S_ADDR_LO: r_state <= S_ADDR_HI;
                S_ADDR_HI: begin
                    r_state     <= S_DATA;
                    r_ext_read  <= !r_we;
                    r_ext_write <= r_we;
                    // r_cnt holds the 1-based index of the current DATA cycle.
                    r_cnt       <= CNT_W'(1);
                end
                S_DATA: begin
                    // IO registers answer in one cycle. Off-chip targets wait
                    // for EXT_READY. EXT_READY beats the timeout in the last
                    // cycle.
                    if (r_cls == C_IO || bus.EXT_READY || r_cnt == TO_VAL) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_ext_read  <= 1'b0;
                        r_ext_write <= 1'b0;
                        if (r_cls == C_IO) begin
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= r_we ? 8'h00 : EXT_AD[7:0];
                        end else if (bus.EXT_READY) begin
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= r_we ? 8'h00 : bus.DT;
                        end else begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 8'h00;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // AE changes only on falling edges. Every rising edge during an address
    // beat then sees AE and EXT_AD stable. AE falls half a cycle into DATA,
    // so write data is already on the bus when AE falls.
    always_ff @(negedge clk) begin
        if (rst)
            r_ae <= 1'b0;
        else
            r_ae <= (r_state == S_ADDR_LO) || (r_state == S_ADDR_HI);
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.EXT_read  = r_ext_read;
    assign bus.EXT_write = r_ext_write;
    assign bus.AE        = r_ae;

endmodule

// File: tb/tb_ext_bus_master.sv
// ---------------------------------------------------------------------------
// tb_ext_bus_master
// Bench for ext_bus_master. It contains a small IO-register target and an
// off-chip target on EXT_AD/EXT_READY/DT, plus a transaction-level reference
// model. The model predicts response latency, error, read data, address
// beats and data-phase length from the address class and target timing.
// ---------------------------------------------------------------------------
module tb_ext_bus_master;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ext_bus_master_if bus();
    wire [15:0] ext_ad;

    ext_bus_master #(.TIMEOUT(TIMEOUT), .IO_TAG(12'h1A1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .EXT_AD (ext_ad)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Bus-side IO register file (what the interface latched) and reference copy.
    logic [7:0] io_regs [16];
    logic [7:0] ref_io  [16];
    logic       io_rd_sel = 1'b0;
    logic [3:0] io_rd_idx = 4'h0;

    assign ext_ad = (bus.EXT_read && io_rd_sel) ? {8'h00, io_regs[io_rd_idx]} : 16'hzzzz;

    // Bus monitor: sampled between the falling edge and the next rising edge,
    // which is the window the interface sees at that rising edge.
    logic [15:0] beats [$];
    int          strobe_cyc;
    bit          saw_rd, saw_wr;
    bit          fall_seen, fall_wr;
    logic [7:0]  fall_data;

    always @(negedge clk) begin
        #2;
        if (bus.AE === 1'b1) beats.push_back(ext_ad);
        if (bus.EXT_read === 1'b1 || bus.EXT_write === 1'b1) strobe_cyc++;
        if (bus.EXT_read === 1'b1)  saw_rd = 1'b1;
        if (bus.EXT_write === 1'b1) saw_wr = 1'b1;
    end

    always @(negedge bus.AE) begin
        fall_seen = 1'b1;
        fall_wr   = bus.EXT_write;
        fall_data = ext_ad[7:0];
    end

    typedef enum int {K_IO, K_UNM, K_OFF} cls_t;

    function automatic cls_t classify(input logic [31:0] a);
        if (a[31:20] == 12'h1A1 && a[19:17] == 3'b000) return K_IO;
        if (a[31:12] == 20'h0) return K_UNM;
        return K_OFF;
    endfunction

    // One request, issued from a falling edge. ready_at is the 1-based
    // DATA cycle in which the off-chip target raises EXT_READY (0 = never).
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [7:0] wdata,
                          input int ready_at, input logic [7:0] dt);
        cls_t       c;
        int         exp_lat, exp_dcyc, exp_beats, n, k, d;
        bit         exp_err, ok, got, strobe;
        logic [7:0] exp_rd;

        c = classify(addr);
        exp_rd = 8'h00;
        case (c)
            K_UNM: begin exp_lat = 1; exp_err = 1'b1; exp_beats = 0; exp_dcyc = 0; end
            K_IO: begin
                exp_lat = 4; exp_err = 1'b0; exp_beats = 2; exp_dcyc = 1;
                if (!we) exp_rd = ref_io[addr[3:0]];
            end
            default: begin
                ok = (ready_at >= 1) && (ready_at <= TIMEOUT);
                d = ok ? ready_at : TIMEOUT;
                exp_lat = 3 + d; exp_err = !ok; exp_beats = 2; exp_dcyc = d;
                if (ok && !we) exp_rd = dt;
            end
        endcase

        beats.delete();
        strobe_cyc = 0; saw_rd = 1'b0; saw_wr = 1'b0; fall_seen = 1'b0; fall_wr = 1'b0;
        io_rd_sel = (c == K_IO) && !we;
        io_rd_idx = addr[3:0];

        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;

        n = 0; k = 0; got = 1'b0;
        while (n < 400 && !got) begin
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                strobe = bus.EXT_read || bus.EXT_write;
                if (strobe) k++;
                bus.EXT_READY = strobe && (k == ready_at);
                bus.DT        = (strobe && k == ready_at) ? dt : 8'($urandom);
                n++;
                @(negedge clk);
            end
        end
        bus.EXT_READY = 1'b0;

        if (!got) begin
            check("rsp_arrived", 32'd0, 32'd1);
        end else begin
            check("latency",     n + 1,                          exp_lat);
            check("rsp_err",     {31'd0, bus.rsp_err},           {31'd0, exp_err});
            check("rsp_rdata",   {24'd0, bus.rsp_rdata},         {24'd0, exp_rd});
            check("strobes_off", {30'd0, bus.EXT_read, bus.EXT_write}, 32'd0);
            check("busy_in_rsp", {31'd0, bus.req_ready},         32'd0);
        end
        #3;
        check("beat_count", beats.size(), exp_beats);
        if (beats.size() == 2 && exp_beats == 2) begin
            check("beat_lo", {16'd0, beats[0]}, {16'd0, addr[15:0]});
            check("beat_hi", {16'd0, beats[1]}, {16'd0, addr[31:16]});
        end
        check("data_cycles", strobe_cyc, exp_dcyc);
        check("read_strobe",  {31'd0, saw_rd}, {31'd0, (!we && c != K_UNM)});
        check("write_strobe", {31'd0, saw_wr}, {31'd0, (we && c != K_UNM)});
        if (we && c != K_UNM)
            check("wdata_at_ae_fall", {22'd0, fall_seen, fall_wr, fall_data}, {22'd0, 1'b1, 1'b1, wdata});
        if (c == K_IO && we) begin
            ref_io[addr[3:0]]  = wdata;
            io_regs[addr[3:0]] = fall_data;
        end
        io_rd_sel = 1'b0;
        @(negedge clk);
        check("rsp_one_cycle",  {31'd0, bus.rsp_valid}, 32'd0);
        check("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bit          any_rsp;
        int          sel;

        for (int i = 0; i < 16; i++) begin io_regs[i] = 8'h00; ref_io[i] = 8'h00; end
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 8'h00;
        bus.EXT_READY = 1'b0; bus.DT = 8'h00;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_ae",        {31'd0, bus.AE},        32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        check("rst_strobes",   {30'd0, bus.EXT_read, bus.EXT_write}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_req(1'b1, 32'h1A10_0004, 8'hA5, 0, 8'h00);
        do_req(1'b1, 32'h1A10_0008, 8'h3C, 0, 8'h00);
        do_req(1'b0, 32'h1A10_0008, 8'h00, 0, 8'h00);
        do_req(1'b0, 32'h1A10_0004, 8'h00, 0, 8'h00);
        do_req(1'b0, 32'h0001_2345, 8'h00, 6, 8'h77);
        do_req(1'b0, 32'h0002_0000, 8'h00, 0, 8'h55);
        do_req(1'b0, 32'h0002_0000, 8'h00, TIMEOUT, 8'h9E);
        do_req(1'b1, 32'h0003_0010, 8'h42, 1, 8'h00);
        do_req(1'b0, 32'h0000_0FFF, 8'h00, 0, 8'h00);

        // Reset during ADDR_HI aborts the access without a response.
        bus.req_valid = 1'b1; bus.req_we = 1'b1;
        bus.req_addr = 32'h1A10_000C; bus.req_wdata = 8'hEE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #2;
        check("abort_ae",        {31'd0, bus.AE},        32'd0);
        check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_strobes",   {30'd0, bus.EXT_read, bus.EXT_write}, 32'd0);
        rst = 1'b0;
        any_rsp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) any_rsp = 1'b1;
        end
        check("abort_no_rsp", {31'd0, any_rsp}, 32'd0);
        do_req(1'b1, 32'h1A10_000C, 8'h5A, 0, 8'h00);
        do_req(1'b0, 32'h1A10_000C, 8'h00, 0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                a = {12'h1A1, 3'b000, 13'($urandom), 4'($urandom)};
            end else if (sel == 1) begin
                a = {20'h0, 12'($urandom)};
            end else begin
                a = $urandom;
                while (classify(a) != K_OFF) a = $urandom;
            end
            do_req(1'($urandom), a, 8'($urandom), $urandom_range(0, TIMEOUT + 3), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
